fp16_to_fixed: RTL and testbench

- Multi-cycle decoder that converts one IEEE-754 half-precision operand into a signed two's-complement fixed-point value.
- Performs the reverse of the FP16 pack path (normalize/round/pack): unpacks fields, restores the hidden bit, aligns by exponent, rounds and saturates.
- Sits between the FP16 arithmetic macros and integer/fixed-point consumers.
- Uses valid/ready handshakes on both sides, with a serial one-bit-per-cycle alignment shifter.

---
 rtl/fp16_pkg.sv | 13 +
 rtl/fp16_fix_rounder.sv | 22 ++
 rtl/fp16_to_fixed.sv | 120 ++++++++++++
 tb/tb_fp16_to_fixed.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 field constants, decoder FSM states and the operand field layout.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int EXP_BIAS = 15;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'b11111;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;
endpackage

// File: rtl/fp16_fix_rounder.sv
// fp16_fix_rounder: round-to-nearest-even, sign apply and saturation of an aligned magnitude.
module fp16_fix_rounder #(
  parameter int OUT_W = 24
) (
  input  logic [OUT_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  output logic [OUT_W-1:0] fix,
  output logic             ovf,
  output logic             inexact
);
  logic [OUT_W:0] rnd;
  logic [OUT_W:0] lim;
  assign rnd = {1'b0, mag} + (OUT_W+1)'(guard & (sticky | mag[0]));
  // Negative range reaches one step further than positive.
  assign lim = {2'b01, {(OUT_W-1){1'b0}}} - (OUT_W+1)'(!sign);
  assign ovf = rnd > lim;
  assign inexact = guard | sticky;
  assign fix = ovf ? (sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                   : (sign ? -rnd[OUT_W-1:0] : rnd[OUT_W-1:0]);
endmodule

// File: rtl/fp16_to_fixed.sv
// fp16_to_fixed: FP16 to signed Q(INT_W.FRAC_W) decoder with valid/ready handshakes.
// Define FP16_FIX_FASTSHIFT_EN for a single-cycle barrel alignment instead of the serial shifter.
module fp16_to_fixed
  import fp16_pkg::*;
#(
  parameter int INT_W = 16,
  parameter int FRAC_W = 8,
  localparam int OUT_W = INT_W + FRAC_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [15:0]      fp_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] fix_o,
  output logic             ovf_o,
  output logic             inexact_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  fp16_t f;
  state_t state;
  logic sign, left, guard, sticky, sat;
  logic [OUT_W-1:0] mag;
  logic [4:0] cnt;
  logic [EXP_W-1:0] e_eff;
  logic [6:0] k, abs_k;
  logic [OUT_W-1:0] r_fix;
  logic r_ovf, r_inexact;
  assign f = fp_i;
  assign e_eff = f.exp == '0 ? EXP_W'(1) : f.exp;
  assign k = 7'(e_eff) - 7'(EXP_BIAS + MANT_W - FRAC_W);
  assign abs_k = k[6] ? 7'(-k) : k;
  assign in_ready_o = state == IDLE;
`ifdef FP16_FIX_FASTSHIFT_EN
  logic [OUT_W+MANT_W:0] ext;
  logic [OUT_W-1:0] mask, disc, f_mag;
  logic f_guard, f_sticky, f_ovf;
  always_comb begin
    ext = {{OUT_W{1'b0}}, mag[MANT_W:0]} << cnt;
    mask = (OUT_W'(1) << cnt) - OUT_W'(1);
    disc = mag & mask;
    f_mag = left ? ext[OUT_W-1:0] : mag >> cnt;
    f_guard = !left & (|(disc >> (cnt - 5'd1)));
    f_sticky = !left & (|(disc & (mask >> 1)));
    f_ovf = left & (|ext[OUT_W+MANT_W:OUT_W]);
  end
`endif
  fp16_fix_rounder #(.OUT_W(OUT_W)) u_rounder (
    .mag(sat ? {OUT_W{1'b1}} : mag),
    .guard(guard),
    .sticky(sticky),
    .sign(sign),
    .fix(r_fix),
    .ovf(r_ovf),
    .inexact(r_inexact)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      sign <= 1'b0;
      left <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      sat <= 1'b0;
      mag <= '0;
      cnt <= '0;
      fix_o <= '0;
      ovf_o <= 1'b0;
      inexact_o <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          sign <= f.sign;
          mag <= OUT_W'({f.exp != '0, f.mant});
          left <= !k[6];
          cnt <= (k[6] && abs_k > 7'd12) ? 5'd12 : abs_k[4:0];
          guard <= 1'b0;
          sticky <= 1'b0;
          sat <= f.exp == EXP_MAX;
          state <= f.exp == EXP_MAX ? ROUND : SHIFT;
        end
        SHIFT: begin
`ifdef FP16_FIX_FASTSHIFT_EN
          mag <= f_mag;
          guard <= f_guard;
          sticky <= f_sticky;
          sat <= sat | f_ovf;
          state <= ROUND;
`else
          if (cnt != '0) begin
            cnt <= cnt - 5'd1;
            if (left) begin
              sat <= sat | mag[OUT_W-1];
              mag <= mag << 1;
            end else begin
              sticky <= sticky | guard;
              guard <= mag[0];
              mag <= mag >> 1;
            end
          end else state <= ROUND;
`endif
        end
        ROUND: begin
          fix_o <= r_fix;
          ovf_o <= r_ovf;
          inexact_o <= r_inexact;
          out_valid_o <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_to_fixed.sv
// tb_fp16_to_fixed: directed and random FP16 conversions checked against an arithmetic model.
module tb_fp16_to_fixed;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] fp = '0;
  logic in_ready, ovf, inexact, out_valid;
  logic [23:0] fix;
  int assertions = 0, failures = 0;

  fp16_to_fixed dut (
    .clk_i(clk), .rst_n_i(rst_n), .fp_i(fp), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fix_o(fix), .ovf_o(ovf), .inexact_o(inexact), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact value * 2^8 = M * 2^(E_eff-17); rounding decided from the true remainder.
  task automatic model(input logic [15:0] v, output logic [23:0] fx, output logic o,
                       output logic ix, output int n);
    int e, m, k, s;
    longint q, rem, half, lim;
    e = int'(v[14:10]);
    m = (e != 0 ? 1024 : 0) + int'(v[9:0]);
    if (e == 0) e = 1;
    k = e - 25 + 8;
    o = 0; ix = 0; q = 0; n = -1;
    if (v[14:10] == 5'd31) o = 1;
    else if (k >= 0) begin
      q = longint'(m) << k;
      n = k;
    end else begin
      s = -k;
      q = longint'(m) >> s;
      rem = longint'(m) - (q << s);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && q[0])) q++;
      ix = rem != 0;
      n = s > 12 ? 12 : s;
    end
`ifdef FP16_FIX_FASTSHIFT_EN
    if (n > 0) n = 0;
`endif
    lim = v[15] ? 64'h800000 : 64'h7FFFFF;
    if (o || q > lim) begin
      o = 1;
      fx = v[15] ? 24'h800000 : 24'h7FFFFF;
    end else fx = v[15] ? 24'(-q) : 24'(q);
  endtask

  task automatic convert(input logic [15:0] v);
    logic [23:0] efx;
    logic eo, eix;
    int n, edges;
    model(v, efx, eo, eix, n);
    check("in_ready", 32'(in_ready), 1);
    fp = v;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("fix[%h]", v), 32'(fix), 32'(efx));
    check($sformatf("ovf[%h]", v), 32'(ovf), 32'(eo));
    check($sformatf("inexact[%h]", v), 32'(inexact), 32'(eix));
    if (n >= 0) check($sformatf("latency[%h]", v), edges, n + 3);
    else check($sformatf("valid[%h]", v), 32'(out_valid), 1);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("valid_drop", 32'(out_valid), 0);
  endtask

  typedef struct { logic [15:0] v; logic [23:0] fx; logic o, ix; } vec_t;
  vec_t dir [9] = '{
    '{16'h3C00, 24'h000100, 0, 0}, '{16'hC500, 24'hFFFB00, 0, 0},
    '{16'h7BFF, 24'h7FFFFF, 1, 0}, '{16'hFC00, 24'h800000, 1, 0},
    '{16'h1800, 24'h000000, 0, 1}, '{16'h1E00, 24'h000002, 0, 1},
    '{16'h0001, 24'h000000, 0, 1}, '{16'h0000, 24'h000000, 0, 0},
    '{16'h8000, 24'h000000, 0, 0}};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_fix", 32'(fix), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_flags", {30'b0, ovf, inexact}, 0);
    rst_n = 1;
    check("rst_ready", 32'(in_ready), 1);
    foreach (dir[i]) begin
      convert(dir[i].v);
      check($sformatf("const_fix[%h]", dir[i].v), 32'(fix), 32'(dir[i].fx));
      check($sformatf("const_flags[%h]", dir[i].v), {30'b0, ovf, inexact}, {30'b0, dir[i].o, dir[i].ix});
    end
    // Backpressure with a stray request that must be ignored.
    fp = 16'h3C00;
    in_valid = 1;
    @(posedge clk); #1;
    fp = 16'hC500;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_fix", 32'(fix), 32'h100);
      check("bp_flags", {30'b0, ovf, inexact}, 0);
      check("bp_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(in_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_single", 32'(out_valid), 0);
    // Reset while the slow subnormal alignment is running.
    fp = 16'h0001;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_fix", 32'(fix), 0);
    check("midrst_flags", {30'b0, ovf, inexact}, 0);
    check("midrst_ready", 32'(in_ready), 1);
    convert(16'h3C00);
    check("post_rst_fix", 32'(fix), 32'h100);
    for (int i = 0; i < 300; i++) convert(16'($urandom_range(0, 65535)));
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
